// File: rtl/countdown_timer.sv
// Loadable down-counter with a selectable tick rate.
//
// A start request in idle latches a 4-bit load value and a tick period chosen by speed_i.
// A rate divider then decrements the count once per period until it reaches zero. On the
// decrement that reaches zero, done_o pulses for one cycle and the block returns to idle.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          level; acted on only in idle
//   pause_i          level; freezes the countdown while high
//   speed_i          period select, latched at an accepted start
//   load_value_i     initial count, latched at an accepted start
//   counter_value_o  current count (registered)
//   busy_o           high while running or paused
//   done_o           one-cycle registered pulse when the count reaches zero
module countdown_timer #(
    parameter int unsigned CntW = 4,
    parameter int unsigned DivW = 11,
    parameter int unsigned Per0 = 1,
    parameter int unsigned Per1 = 500,
    parameter int unsigned Per2 = 1000,
    parameter int unsigned Per3 = 2000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            pause_i,
    input  logic [1:0]      speed_i,
    input  logic [CntW-1:0] load_value_i,
    output logic [CntW-1:0] counter_value_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StPaused = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [DivW-1:0] div_q, div_d;
    logic [DivW-1:0] per_q, per_d;
    logic            done_q, done_d;

    logic [DivW-1:0] per_sel;
    logic            busy;
    logic            advance;
    logic            tick;
    logic            last;

    always_comb begin
        unique case (speed_i)
            2'b00:   per_sel = DivW'(Per0);
            2'b01:   per_sel = DivW'(Per1);
            2'b10:   per_sel = DivW'(Per2);
            default: per_sel = DivW'(Per3);
        endcase
    end

    // The unused state encoding is not busy, so it follows the idle path everywhere.
    assign busy = (state_q == StRun) || (state_q == StPaused);

    // Releasing pause resumes on the same edge, so a pause of N cycles costs exactly
    // N cycles of delay. Divider and count are never altered by pausing.
    assign advance = busy && !pause_i;
    assign tick    = advance && (div_q == '0);
    assign last    = tick && (count_q == CntW'(1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            count_q <= '0;
            div_q   <= '0;
            per_q   <= DivW'(Per0);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            per_q   <= per_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_i && (load_value_i != '0)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (pause_i) begin
                    state_d = StPaused;
                end else if (last) begin
                    state_d = StIdle;
                end
            end
            StPaused: begin
                if (!pause_i) begin
                    state_d = last ? StIdle : StRun;
                end
            end
            default: begin
                state_d = (start_i && (load_value_i != '0)) ? StRun : StIdle;
            end
        endcase
    end

    // Datapath next-state logic
    always_comb begin
        count_d = count_q;
        div_d   = div_q;
        per_d   = per_q;
        done_d  = 1'b0;
        if (busy) begin
            if (tick) begin
                div_d   = per_q - DivW'(1);
                count_d = count_q - CntW'(1);
                done_d  = last;
            end else if (advance) begin
                div_d = div_q - DivW'(1);
            end
        end else if (start_i) begin
            if (load_value_i != '0) begin
                count_d = load_value_i;
                per_d   = per_sel;
                div_d   = per_sel - DivW'(1);
            end else begin
                // A zero load completes immediately without entering the run state.
                count_d = '0;
                done_d  = 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        counter_value_o = count_q;
        busy_o          = busy;
        done_o          = done_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic [1:0] speed;
    logic [3:0] load;
    logic [3:0] count;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Reference model: elapsed un-paused edges since the accepted start determine the
    // remaining count as L - floor(progress / P).
    bit m_busy;
    bit m_done;
    int m_cnt;
    int m_load;
    int m_per;
    int m_prog;

    always #5 clk = ~clk;

    countdown_timer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .pause_i        (pause),
        .speed_i        (speed),
        .load_value_i   (load),
        .counter_value_o(count),
        .busy_o         (busy),
        .done_o         (done)
    );

    function automatic int period_of(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 500;
            2'd2:    return 1000;
            default: return 2000;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_cnt  = 0;
        m_load = 0;
        m_per  = 1;
        m_prog = 0;
    endtask

    // Advance one rising edge, update the model from the inputs seen at that edge,
    // and leave time 1 unit past the edge for sampling.
    task automatic step();
        @(posedge clk);
        m_done = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            if (start) begin
                if (load == 4'd0) begin
                    m_cnt  = 0;
                    m_done = 1'b1;
                end else begin
                    m_load = int'(load);
                    m_cnt  = m_load;
                    m_per  = period_of(speed);
                    m_prog = 0;
                    m_busy = 1'b1;
                end
            end
        end else if (!pause) begin
            m_prog++;
            m_cnt = m_load - m_prog / m_per;
            if (m_cnt == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        speed = 2'd0;
        load  = 4'd0;
        model_reset();
        #12;
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d busy=%b done=%b expected 0 0 0",
                     count, busy, done);
        end
        rst_n = 1'b1;
        step();
        speed = 2'd0;
        load  = 4'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++;
        if (count !== 4'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun: got cnt=%0d busy=%b expected cnt=5 busy=1", count, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got cnt=%0d busy=%b done=%b expected 0 0 0",
                     count, busy, done);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if (count !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: got cnt=%0d busy=%b expected cnt=0 busy=0", count, busy);
        end
    endtask

    task automatic test_speed0();
        speed = 2'd0;
        load  = 4'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        load  = 4'd0;
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) step();
            checks++;
            if (count !== 4'(5 - i) || busy !== (i < 5) || done !== (i == 5)) begin
                errors++;
                $display("FAIL speed0 edge k+%0d: got cnt=%0d busy=%b done=%b expected cnt=%0d busy=%b done=%b",
                         i, count, busy, done, 5 - i, i < 5, i == 5);
            end
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL speed0_after: got cnt=%0d busy=%b done=%b expected 0 0 0",
                     count, busy, done);
        end
    endtask

    task automatic test_speed1();
        int done_edge = -1;
        int dones     = 0;
        speed = 2'd1;
        load  = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 1510; e++) begin
            if (e == 10) speed = 2'd3;
            step();
            if (done === 1'b1) begin
                dones++;
                done_edge = e;
            end
            if ((e == 499 || e == 500 || e == 1000 || e == 1499 || e == 1500 || e == 1510) &&
                (count !== 4'(m_cnt) || busy !== m_busy || done !== m_done)) begin
                errors++;
                $display("FAIL speed1 edge k+%0d: got cnt=%0d busy=%b done=%b expected cnt=%0d busy=%b done=%b",
                         e, count, busy, done, m_cnt, m_busy, m_done);
            end
            if (e == 499 || e == 500 || e == 1000 || e == 1499 || e == 1500 || e == 1510) checks++;
        end
        checks++;
        if (dones != 1 || done_edge != 1500) begin
            errors++;
            $display("FAIL speed1_done: got count=%0d at k+%0d expected 1 at k+1500",
                     dones, done_edge);
        end
    endtask

    task automatic test_pause();
        int dec1 = -1;
        int dec2 = -1;
        speed = 2'd2;
        load  = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 2040; e++) begin
            step();
            if (e == 999) pause = 1'b1;
            if (e == 1036) pause = 1'b0;
            if (count === 4'd1 && dec1 < 0) dec1 = e;
            if (count === 4'd0 && dec2 < 0) dec2 = e;
            checks++;
            if (count !== 4'(m_cnt) || busy !== m_busy || done !== m_done) begin
                errors++;
                $display("FAIL pause edge k+%0d: got cnt=%0d busy=%b done=%b expected cnt=%0d busy=%b done=%b",
                         e, count, busy, done, m_cnt, m_busy, m_done);
            end
        end
        checks++;
        if (dec1 != 1037 || dec2 != 2037) begin
            errors++;
            $display("FAIL pause_timing: got decrements at k+%0d,k+%0d expected k+1037,k+2037",
                     dec1, dec2);
        end
    endtask

    task automatic test_zero_and_ignore();
        speed = 2'd0;
        load  = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL zero_load: got cnt=%0d busy=%b done=%b expected cnt=0 busy=0 done=1",
                     count, busy, done);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_load_after: got busy=%b done=%b expected 0 0", busy, done);
        end
        load  = 4'd4;
        start = 1'b1;
        step();
        load = 4'd9;
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if (count !== 4'(4 - i) || busy !== 1'b1) begin
                errors++;
                $display("FAIL ignore_start %0d: got cnt=%0d busy=%b expected cnt=%0d busy=1",
                         i, count, busy, 4 - i);
            end
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (busy !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL ignore_end: got cnt=%0d busy=%b expected cnt=0 busy=0", count, busy);
        end
    endtask

    task automatic test_auto_restart();
        int first = -1;
        int prev  = -1;
        int dones = 0;
        speed = 2'd0;
        load  = 4'hF;
        start = 1'b1;
        step();
        for (int e = 1; e <= 50; e++) begin
            step();
            checks++;
            if (count !== 4'(m_cnt) || busy !== m_busy || done !== m_done) begin
                errors++;
                $display("FAIL restart edge k+%0d: got cnt=%0d busy=%b done=%b expected cnt=%0d busy=%b done=%b",
                         e, count, busy, done, m_cnt, m_busy, m_done);
            end
            if (done === 1'b1) begin
                if (first < 0) first = e;
                if (prev >= 0 && e - prev != 16) begin
                    errors++;
                    $display("FAIL restart_gap: got %0d expected 16", e - prev);
                end
                if (prev >= 0) checks++;
                prev = e;
                dones++;
            end
            if (e == 16) begin
                checks++;
                if (count !== 4'hF) begin
                    errors++;
                    $display("FAIL restart_reload: got cnt=%0d expected 15", count);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (dones != 3 || first != 15) begin
            errors++;
            $display("FAIL restart_dones: got %0d first at k+%0d expected 3 first at k+15",
                     dones, first);
        end
        for (int i = 0; i < 20; i++) step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 5) == 0);
            pause = ($urandom_range(0, 6) == 0);
            speed = ($urandom_range(0, 40) == 0) ? 2'd1 : 2'd0;
            load  = 4'($urandom_range(0, 15));
            step();
            checks++;
            if (count !== 4'(m_cnt) || busy !== m_busy || done !== m_done) begin
                errors++;
                $display("FAIL random cycle %0d: got cnt=%0d busy=%b done=%b expected cnt=%0d busy=%b done=%b",
                         i, count, busy, done, m_cnt, m_busy, m_done);
            end
        end
        start = 1'b0;
        pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_speed0();
        test_speed1();
        test_pause();
        test_zero_and_ignore();
        test_auto_restart();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
